// File: rtl/task_fifo_multi_queue.sv
// Per-tree task buffer: TREE_NUM FIFO queues in one shared memory, drained by a round-robin
// arbiter that issues at most one task per cycle to the tree pipeline.
module task_fifo_multi_queue #(
  parameter int unsigned PTW           = 16,
  parameter int unsigned TREE_NUM      = 4,
  parameter int unsigned TREE_NUM_BITS = $clog2(TREE_NUM),
  parameter int unsigned BUF_SIZE      = 8,
  parameter int unsigned BUF_WIDTH     = $clog2(BUF_SIZE),
  parameter int unsigned AFULL_LVL     = BUF_SIZE - 2
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                wr_en,
  input  logic [PTW+TREE_NUM_BITS:0]          buf_in,
  input  logic                                rd_en,
  input  logic [TREE_NUM-1:0]                 tree_busy,
  output logic [PTW+TREE_NUM_BITS:0]          buf_out,
  output logic                                out_valid,
  output logic [TREE_NUM_BITS-1:0]            out_tree,
  output logic [TREE_NUM-1:0]                 q_empty,
  output logic [TREE_NUM-1:0]                 q_full,
  output logic [TREE_NUM-1:0]                 q_afull,
  output logic [TREE_NUM*(BUF_WIDTH+1)-1:0]   q_count,
  output logic                                wr_drop
);

  localparam int unsigned TaskW = PTW + TREE_NUM_BITS + 1;
  localparam int unsigned CntW  = BUF_WIDTH + 1;
  localparam int unsigned AddrW = TREE_NUM_BITS + BUF_WIDTH;

  logic [TaskW-1:0]         mem [TREE_NUM*BUF_SIZE];

  logic [BUF_WIDTH-1:0]     wr_ptr_q [TREE_NUM];
  logic [BUF_WIDTH-1:0]     wr_ptr_d [TREE_NUM];
  logic [BUF_WIDTH-1:0]     rd_ptr_q [TREE_NUM];
  logic [BUF_WIDTH-1:0]     rd_ptr_d [TREE_NUM];
  logic [CntW-1:0]          cnt_q    [TREE_NUM];
  logic [CntW-1:0]          cnt_d    [TREE_NUM];
  logic [TREE_NUM_BITS-1:0] rr_ptr_q, rr_ptr_d;

  logic [TaskW-1:0]         buf_out_q, buf_out_d;
  logic                     out_valid_q, out_valid_d;
  logic [TREE_NUM_BITS-1:0] out_tree_q, out_tree_d;
  logic                     wr_drop_q, wr_drop_d;

  logic [TREE_NUM_BITS-1:0] wr_tree;
  logic [31:0]              wr_tree_ext;
  logic                     wr_tree_ok, pop_same, push_ok;
  logic [AddrW-1:0]         wr_addr, rd_addr;
  logic [TREE_NUM-1:0]      elig, push_vec, pop_vec;
  logic                     grant_vld;
  logic [TREE_NUM_BITS-1:0] grant_idx, scan_tree;
  int unsigned              scan_idx;

  // Status flags and eligibility, all from registered counts
  always_comb begin
    q_count = '0;
    for (int t = 0; t < TREE_NUM; t++) begin
      q_empty[t]               = (cnt_q[t] == '0);
      q_full[t]                = (cnt_q[t] == CntW'(BUF_SIZE));
      q_afull[t]               = (cnt_q[t] >= CntW'(AFULL_LVL));
      q_count[t*CntW +: CntW]  = cnt_q[t];
      elig[t]                  = (cnt_q[t] != '0) && !tree_busy[t];
    end
  end

  // Round-robin grant starting at rr_ptr; only start-of-cycle counts matter, so no bypass
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    scan_idx  = 0;
    scan_tree = '0;
    for (int i = 0; i < TREE_NUM; i++) begin
      scan_idx  = (32'(rr_ptr_q) + 32'(i)) % TREE_NUM;
      scan_tree = TREE_NUM_BITS'(scan_idx);
      if (rd_en && !grant_vld && elig[scan_tree]) begin
        grant_vld = 1'b1;
        grant_idx = scan_tree;
      end
    end
    rr_ptr_d = grant_vld ? TREE_NUM_BITS'((32'(grant_idx) + 32'd1) % TREE_NUM) : rr_ptr_q;
  end

  // Push acceptance; a full queue still accepts when it is popped in the same cycle
  always_comb begin
    wr_tree     = buf_in[PTW +: TREE_NUM_BITS];
    wr_tree_ext = 32'(wr_tree);
    wr_tree_ok  = (wr_tree_ext < TREE_NUM);
    pop_same    = grant_vld && (grant_idx == wr_tree);
    push_ok     = wr_en && wr_tree_ok && (!q_full[wr_tree] || pop_same);
    wr_addr     = {wr_tree, wr_ptr_q[wr_tree]};
    rd_addr     = {grant_idx, rd_ptr_q[grant_idx]};
  end

  // Per-queue pointer and occupancy next state
  always_comb begin
    for (int t = 0; t < TREE_NUM; t++) begin
      push_vec[t] = push_ok && (wr_tree == TREE_NUM_BITS'(t));
      pop_vec[t]  = grant_vld && (grant_idx == TREE_NUM_BITS'(t));
      wr_ptr_d[t] = wr_ptr_q[t] + BUF_WIDTH'(push_vec[t]);
      rd_ptr_d[t] = rd_ptr_q[t] + BUF_WIDTH'(pop_vec[t]);
      cnt_d[t]    = cnt_q[t] + CntW'(push_vec[t]) - CntW'(pop_vec[t]);
    end
  end

  // Issue-side output register next state; memory read sees pre-write contents
  always_comb begin
    out_valid_d = grant_vld;
    buf_out_d   = grant_vld ? mem[rd_addr] : '0;
    out_tree_d  = grant_vld ? grant_idx : '0;
    wr_drop_d   = wr_en && !push_ok;
  end

  // Shared task memory, intentionally not reset
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_addr] <= buf_in;
    end
  end

  // Control state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int t = 0; t < TREE_NUM; t++) begin
        wr_ptr_q[t] <= '0;
        rd_ptr_q[t] <= '0;
        cnt_q[t]    <= '0;
      end
      rr_ptr_q    <= '0;
      buf_out_q   <= '0;
      out_valid_q <= 1'b0;
      out_tree_q  <= '0;
      wr_drop_q   <= 1'b0;
    end else begin
      for (int t = 0; t < TREE_NUM; t++) begin
        wr_ptr_q[t] <= wr_ptr_d[t];
        rd_ptr_q[t] <= rd_ptr_d[t];
        cnt_q[t]    <= cnt_d[t];
      end
      rr_ptr_q    <= rr_ptr_d;
      buf_out_q   <= buf_out_d;
      out_valid_q <= out_valid_d;
      out_tree_q  <= out_tree_d;
      wr_drop_q   <= wr_drop_d;
    end
  end

  assign buf_out   = buf_out_q;
  assign out_valid = out_valid_q;
  assign out_tree  = out_tree_q;
  assign wr_drop   = wr_drop_q;

endmodule
